// File: rtl/board_nxn.sv
// N x N, K-in-a-row game board: holds cell ownership, validates moves and
// scans the four lines through each new stone to flag win, draw and winner.
module board_nxn #(
   parameter int   N      = 3,
   parameter int   K      = 3,
   parameter int   ADDR_W = 4,
   parameter logic FIRST  = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                new_game,
   input  logic                move_valid,
   input  logic                move_side,
   input  logic [ADDR_W-1:0]   move_addr,
   output logic                move_ready,
   output logic [2*N*N-1:0]    board_data,
   output logic                illegal_move,
   output logic                turn,
   output logic                busy,
   output logic                win,
   output logic                draw,
   output logic [1:0]          winner,
   output logic [ADDR_W:0]     move_count
);

   localparam int CELLS = N * N;
   localparam int CW    = $clog2(N) + 2;

   localparam logic signed [CW-1:0] NS      = CW'(N);
   localparam logic signed [CW-1:0] OFF_MIN = CW'(-(K - 1));
   localparam logic signed [CW-1:0] OFF_MAX = CW'(K - 1);
   localparam logic signed [CW-1:0] OFF_ONE = CW'(1);
   localparam logic [CW-1:0]        RUN_ONE = CW'(1);
   localparam logic [CW-1:0]        KU      = CW'(K);
   localparam logic [ADDR_W:0]      CELLS_W = (ADDR_W + 1)'(CELLS);
   localparam logic [ADDR_W:0]      CNT_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0]    NA      = ADDR_W'(N);

   typedef enum logic [1:0] {IDLE, CHECK, OVER} stateT;

   stateT r_state;
   stateT w_stateNext;

   logic [1:0]           r_cells [CELLS];
   logic                 r_turn;
   logic                 r_win;
   logic                 r_draw;
   logic                 r_illegal;
   logic [1:0]           r_winner;
   logic [ADDR_W:0]      r_count;
   logic signed [CW-1:0] r_row;
   logic signed [CW-1:0] r_col;
   logic [1:0]           r_code;
   logic [1:0]           r_dir;
   logic signed [CW-1:0] r_off;
   logic [CW-1:0]        r_run;
   logic                 r_found;

   logic                 w_addrBad;
   logic                 w_cellFull;
   logic                 w_legal;
   logic                 w_request;
   logic                 w_accept;
   logic                 w_reject;
   logic signed [CW-1:0] w_tr;
   logic signed [CW-1:0] w_tc;
   logic                 w_inBounds;
   logic [ADDR_W-1:0]    w_idx;
   logic                 w_hit;
   logic [CW-1:0]        w_runNext;
   logic                 w_foundNext;
   logic                 w_lastStep;
   logic                 w_scanDone;
   logic                 w_ready;
   logic                 w_busy;

   assign w_addrBad  = {1'b0, move_addr} >= CELLS_W;
   assign w_cellFull = !w_addrBad && (r_cells[move_addr] != 2'b00);
   assign w_legal    = !w_addrBad && !w_cellFull && (move_side == r_turn);
   assign w_request  = (r_state == IDLE) && move_valid;
   assign w_accept   = w_request && w_legal;
   assign w_reject   = w_request && !w_legal;

   // Target cell for the current direction and offset; signed so that
   // coordinates running off any edge show up as negative or >= N.
   always_comb begin
      w_tr = r_row;
      w_tc = r_col;
      case (r_dir)
         2'd0: w_tc = r_col + r_off;
         2'd1: w_tr = r_row + r_off;
         2'd2: begin
            w_tr = r_row + r_off;
            w_tc = r_col + r_off;
         end
         default: begin
            w_tr = r_row + r_off;
            w_tc = r_col - r_off;
         end
      endcase
   end

   assign w_inBounds  = !w_tr[CW-1] && (w_tr < NS) && !w_tc[CW-1] && (w_tc < NS);
   assign w_idx       = ADDR_W'(32'(w_tr) * N + 32'(w_tc));
   assign w_hit       = w_inBounds && (r_cells[w_idx] == r_code);
   assign w_runNext   = w_hit ? (r_run + RUN_ONE) : '0;
   assign w_foundNext = r_found || (w_runNext >= KU);
   assign w_lastStep  = (r_off == OFF_MAX);
   assign w_scanDone  = (r_state == CHECK) && w_lastStep && (r_dir == 2'd3);

   always_ff @(posedge clk) begin
      if (rst || new_game) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_ready     = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (w_accept) begin
               w_stateNext = CHECK;
            end
         end
         CHECK: begin
            w_busy = 1'b1;
            if (w_scanDone) begin
               if (w_foundNext || (r_count == CELLS_W)) begin
                  w_stateNext = OVER;
               end else begin
                  w_stateNext = IDLE;
               end
            end
         end
         default: w_stateNext = OVER;
      endcase
   end

   // Board store plus the scan datapath; the scan always walks every offset
   // of every direction so the busy period has a fixed length.
   always_ff @(posedge clk) begin
      if (rst || new_game) begin
         for (int i = 0; i < CELLS; i++) begin
            r_cells[i] <= 2'b00;
         end
         r_turn    <= FIRST;
         r_win     <= 1'b0;
         r_draw    <= 1'b0;
         r_illegal <= 1'b0;
         r_winner  <= 2'b00;
         r_count   <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_code    <= 2'b00;
         r_dir     <= 2'd0;
         r_off     <= OFF_MIN;
         r_run     <= '0;
         r_found   <= 1'b0;
      end else begin
         r_illegal <= w_reject;
         if (w_accept) begin
            r_cells[move_addr] <= {move_side, ~move_side};
            r_count <= r_count + CNT_ONE;
            r_row   <= $signed(CW'(move_addr / NA));
            r_col   <= $signed(CW'(move_addr % NA));
            r_code  <= {move_side, ~move_side};
            r_dir   <= 2'd0;
            r_off   <= OFF_MIN;
            r_run   <= '0;
            r_found <= 1'b0;
         end
         if (r_state == CHECK) begin
            r_found <= w_foundNext;
            if (w_lastStep) begin
               r_off <= OFF_MIN;
               r_dir <= r_dir + 2'd1;
               r_run <= '0;
            end else begin
               r_off <= r_off + OFF_ONE;
               r_run <= w_runNext;
            end
            if (w_scanDone) begin
               if (w_foundNext) begin
                  r_win    <= 1'b1;
                  r_winner <= r_code;
               end else if (r_count == CELLS_W) begin
                  r_draw <= 1'b1;
               end else begin
                  r_turn <= ~r_turn;
               end
            end
         end
      end
   end

   for (genvar gi = 0; gi < CELLS; gi++) begin : g_board
      assign board_data[2*gi +: 2] = r_cells[gi];
   end

   assign move_ready   = w_ready;
   assign busy         = w_busy;
   assign illegal_move = r_illegal;
   assign turn         = r_turn;
   assign win          = r_win;
   assign draw         = r_draw;
   assign winner       = r_winner;
   assign move_count   = r_count;

endmodule

// File: tb/tb_board_nxn.sv
// Bench for board_nxn: a 3x3/K=3 board and a 5x5/K=4 board driven through one
// shared stimulus path, with expected results queued and compared on arrival.
`timescale 1ns/1ps
module tb_board_nxn;

   logic       clk = 1'b0;
   logic       rst;
   logic       newGame;
   logic       moveValid;
   logic       moveSide;
   logic [4:0] moveAddr;
   logic       sel;

   logic        ready3, illegal3, turn3, busy3, win3, draw3;
   logic [1:0]  winner3;
   logic [4:0]  count3;
   logic [17:0] board3;

   logic        ready5, illegal5, turn5, busy5, win5, draw5;
   logic [1:0]  winner5;
   logic [5:0]  count5;
   logic [49:0] board5;

   logic        sReady, sIllegal, sTurn, sBusy, sWin, sDraw;
   logic [1:0]  sWinner;
   logic [5:0]  sCount;
   logic [49:0] sBoard;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } expT;

   expT sbQ[$];
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   board_nxn #(.N(3), .K(3), .ADDR_W(4), .FIRST(1'b0)) u_dut3 (
      .clk(clk), .rst(rst), .new_game(newGame & ~sel),
      .move_valid(moveValid & ~sel), .move_side(moveSide), .move_addr(moveAddr[3:0]),
      .move_ready(ready3), .board_data(board3), .illegal_move(illegal3),
      .turn(turn3), .busy(busy3), .win(win3), .draw(draw3),
      .winner(winner3), .move_count(count3)
   );

   board_nxn #(.N(5), .K(4), .ADDR_W(5), .FIRST(1'b0)) u_dut5 (
      .clk(clk), .rst(rst), .new_game(newGame & sel),
      .move_valid(moveValid & sel), .move_side(moveSide), .move_addr(moveAddr),
      .move_ready(ready5), .board_data(board5), .illegal_move(illegal5),
      .turn(turn5), .busy(busy5), .win(win5), .draw(draw5),
      .winner(winner5), .move_count(count5)
   );

   // Route whichever board is under test onto one set of observation signals.
   always_comb begin
      if (sel) begin
         sReady = ready5;  sIllegal = illegal5; sTurn = turn5; sBusy = busy5;
         sWin = win5; sDraw = draw5; sWinner = winner5; sCount = count5;
         sBoard = board5;
      end else begin
         sReady = ready3;  sIllegal = illegal3; sTurn = turn3; sBusy = busy3;
         sWin = win3; sDraw = draw3; sWinner = winner3; sCount = {1'b0, count3};
         sBoard = {32'b0, board3};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] getCell(input int a);
      return sBoard[2*a +: 2];
   endfunction

   task automatic pushExp(input string tag, input logic [31:0] val);
      expT e;
      e.tag = tag;
      e.val = val;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input logic [31:0] obs);
      expT e;
      checks++;
      if (sbQ.size() == 0) begin
         errors++;
         $error("[TB] FAIL scoreboardEmpty observed=%0h expected=none", obs);
      end else begin
         e = sbQ.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic checkCleared(input string pfx);
      pushExp({pfx, "BoardZero"}, 32'd1);
      pushExp({pfx, "Count"},     32'd0);
      pushExp({pfx, "Ready"},     32'd1);
      pushExp({pfx, "Busy"},      32'd0);
      pushExp({pfx, "Win"},       32'd0);
      pushExp({pfx, "Draw"},      32'd0);
      pushExp({pfx, "Winner"},    32'd0);
      pushExp({pfx, "Turn"},      32'd0);
      pushExp({pfx, "Illegal"},   32'd0);
      checkOutput(32'(sBoard === '0));
      checkOutput(32'(sCount));
      checkOutput(32'(sReady));
      checkOutput(32'(sBusy));
      checkOutput(32'(sWin));
      checkOutput(32'(sDraw));
      checkOutput(32'(sWinner));
      checkOutput(32'(sTurn));
      checkOutput(32'(sIllegal));
   endtask

   task automatic pulseNewGame();
      newGame = 1'b1;
      tick();
      newGame = 1'b0;
      checkCleared("newGame");
   endtask

   // One move request: wait for ready, drive for one edge, then follow the
   // outcome (scan length and flags for a legal move, pulse for a rejected one).
   task automatic applyStimulus(input logic side, input int addr, input bit legal,
                                input logic [1:0] expCell, input logic expWin,
                                input logic expDraw, input logic [1:0] expWinner,
                                input logic expTurn, input int expCount, input int expLen);
      int n;
      n = 0;
      while (sReady !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      assert (sReady === 1'b1) else begin
         errors++;
         $error("[TB] FAIL readyWait observed=%0b expected=1", sReady);
      end
      moveValid = 1'b1;
      moveSide  = side;
      moveAddr  = 5'(addr);
      if (legal) begin
         pushExp("cell", 32'(expCell));
         pushExp("countAfterAccept", 32'(expCount));
         pushExp("busyStart", 32'd1);
         pushExp("busyLength", 32'(expLen));
         pushExp("win", 32'(expWin));
         pushExp("draw", 32'(expDraw));
         pushExp("winner", 32'(expWinner));
         pushExp("turn", 32'(expTurn));
         pushExp("readyAfterScan", 32'(!(expWin || expDraw)));
      end else begin
         pushExp("illegalPulse", 32'd1);
         pushExp("illegalFall", 32'd0);
         pushExp("cellKept", 32'(expCell));
         pushExp("countKept", 32'(expCount));
         pushExp("turnKept", 32'(expTurn));
      end
      tick();
      moveValid = 1'b0;
      if (legal) begin
         checkOutput(32'(getCell(addr)));
         checkOutput(32'(sCount));
         checkOutput(32'(sBusy));
         n = 0;
         while (sBusy === 1'b1 && n < 200) begin
            tick();
            n++;
         end
         checkOutput(32'(n));
         checkOutput(32'(sWin));
         checkOutput(32'(sDraw));
         checkOutput(32'(sWinner));
         checkOutput(32'(sTurn));
         checkOutput(32'(sReady));
      end else begin
         checkOutput(32'(sIllegal));
         tick();
         checkOutput(32'(sIllegal));
         checkOutput(32'(getCell(addr)));
         checkOutput(32'(sCount));
         checkOutput(32'(sTurn));
      end
   endtask

   initial begin
      rst       = 1'b1;
      newGame   = 1'b0;
      moveValid = 1'b0;
      moveSide  = 1'b0;
      moveAddr  = '0;
      sel       = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checkCleared("reset");

      $display("[TB] 3x3 player row win");
      applyStimulus(1'b0, 4, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1, 20);
      applyStimulus(1'b1, 0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2, 20);
      applyStimulus(1'b0, 3, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 3, 20);
      applyStimulus(1'b1, 1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 4, 20);
      applyStimulus(1'b0, 5, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 5, 20);

      // A request while the game is over must be silently dropped.
      moveValid = 1'b1;
      moveSide  = 1'b1;
      moveAddr  = 5'd8;
      pushExp("overNoIllegal", 32'd0);
      pushExp("overCount", 32'd5);
      pushExp("overCell", 32'd0);
      pushExp("overReady", 32'd0);
      tick();
      moveValid = 1'b0;
      checkOutput(32'(sIllegal));
      checkOutput(32'(sCount));
      checkOutput(32'(getCell(8)));
      checkOutput(32'(sReady));

      $display("[TB] 3x3 illegal requests");
      pulseNewGame();
      applyStimulus(1'b0, 4, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1, 20);
      applyStimulus(1'b1, 4, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1, 0);
      applyStimulus(1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1, 0);
      applyStimulus(1'b1, 9, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1, 0);

      $display("[TB] 3x3 full-board draw");
      pulseNewGame();
      applyStimulus(1'b0, 0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1, 20);
      applyStimulus(1'b1, 1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2, 20);
      applyStimulus(1'b0, 2, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 3, 20);
      applyStimulus(1'b1, 4, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 4, 20);
      applyStimulus(1'b0, 3, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 5, 20);
      applyStimulus(1'b1, 5, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 6, 20);
      applyStimulus(1'b0, 7, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 7, 20);
      applyStimulus(1'b1, 6, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 8, 20);
      applyStimulus(1'b0, 8, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 9, 20);

      $display("[TB] 3x3 new game during scan");
      pulseNewGame();
      applyStimulus(1'b0, 4, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1, 20);
      applyStimulus(1'b1, 2, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2, 20);
      moveValid = 1'b1;
      moveSide  = 1'b0;
      moveAddr  = 5'd0;
      tick();
      moveValid = 1'b0;
      pushExp("abortBusyBefore", 32'd1);
      checkOutput(32'(sBusy));
      tick();
      tick();
      tick();
      newGame   = 1'b1;
      moveValid = 1'b1;
      moveSide  = 1'b1;
      moveAddr  = 5'd1;
      tick();
      newGame   = 1'b0;
      moveValid = 1'b0;
      checkCleared("abort");

      $display("[TB] 5x5 K=4 computer diagonal");
      sel = 1'b1;
      checkCleared("big");
      applyStimulus(1'b0, 0,  1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1, 28);
      applyStimulus(1'b1, 6,  1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2, 28);
      applyStimulus(1'b0, 1,  1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 3, 28);
      applyStimulus(1'b1, 12, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 4, 28);
      applyStimulus(1'b0, 2,  1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 5, 28);
      applyStimulus(1'b1, 18, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 6, 28);
      applyStimulus(1'b0, 10, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 7, 28);
      applyStimulus(1'b1, 24, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 8, 28);

      checks++;
      assert (sbQ.size() == 0) else begin
         errors++;
         $error("[TB] FAIL scoreboardLeftover observed=%0d expected=0", sbQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
